// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
// Optional perf counters are enabled with the IFETCH_PERF_CNT_EN macro.
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } ifetch_state_e;

  localparam int unsigned RESET_PC_DEFAULT = 0;

  // BRAM strobes are active low
  localparam logic RD_ON  = 1'b0;
  localparam logic RD_OFF = 1'b1;
  localparam logic WR_ON  = 1'b0;
  localparam logic WR_OFF = 1'b1;

  function automatic logic [31:0] sat_inc32(input logic [31:0] value, input logic en);
    return (en && (value != 32'hFFFF_FFFF)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/ifetch_perf_cnt.sv
// Two saturating 32-bit event counters: accepted instructions and stall cycles.
// Only instantiated when IFETCH_PERF_CNT_EN is defined.
module ifetch_perf_cnt
  import ifetch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_instr_inc,
  input  logic        i_stall_inc,
  output logic [31:0] o_instr_cnt,
  output logic [31:0] o_stall_cnt
);

  logic [31:0] r_instr_cnt;
  logic [31:0] r_stall_cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_cnt <= '0;
      r_stall_cnt <= '0;
    end else begin
      r_instr_cnt <= sat_inc32(r_instr_cnt, i_instr_inc);
      r_stall_cnt <= sat_inc32(r_stall_cnt, i_stall_inc);
    end
  end

  assign o_instr_cnt = r_instr_cnt;
  assign o_stall_cnt = r_stall_cnt;

endmodule

// File: rtl/ifetch_ctrl.sv
// Instruction-fetch sequencer: boot loader port, PC ownership, valid/ready stream
// to decode, redirect and halt. IFETCH_PERF_CNT_EN adds perf counter outputs.
module ifetch_ctrl
  import ifetch_pkg::*;
#(
  parameter int          ADDR_WIDTH = 10,
  parameter int          DATA_WIDTH = 32,
  parameter int unsigned RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd_n,
  output logic                  mem_wr_n,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  busy
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_instr_cnt,
  output logic [31:0]           perf_stall_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] PC_INIT = ADDR_WIDTH'(RESET_PC);

  ifetch_state_e         r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                  r_inflight_valid, w_inflight_valid_nxt;
  logic [ADDR_WIDTH-1:0] r_inflight_pc, w_inflight_pc_nxt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state          <= IDLE;
      r_pc             <= PC_INIT;
      r_inflight_valid <= 1'b0;
      r_inflight_pc    <= '0;
    end else begin
      r_state          <= w_state_nxt;
      r_pc             <= w_pc_nxt;
      r_inflight_valid <= w_inflight_valid_nxt;
      r_inflight_pc    <= w_inflight_pc_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    w_state_nxt          = r_state;
    w_pc_nxt             = r_pc;
    w_inflight_valid_nxt = r_inflight_valid;
    w_inflight_pc_nxt    = r_inflight_pc;
    mem_addr             = r_pc;
    mem_rd_n             = RD_OFF;
    mem_wr_n             = WR_OFF;
    mem_wdata            = ld_data;
    ld_ready             = 1'b0;
    instr_valid          = 1'b0;

    unique case (r_state)
      IDLE, HALT: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_addr = ld_addr;
          mem_wr_n = WR_ON;
        end
        if (start) begin
          w_state_nxt          = RUN;
          w_pc_nxt             = PC_INIT;
          w_inflight_valid_nxt = 1'b0;
        end
      end

      RUN: begin
        if (halt_req) begin
          w_state_nxt          = HALT;
          w_inflight_valid_nxt = 1'b0;
        end else if (redirect_valid) begin
          w_pc_nxt             = redirect_pc;
          w_inflight_valid_nxt = 1'b0;
        end else begin
          instr_valid = r_inflight_valid;
          // mem_rdata only holds while rd_n stays high, so a read may issue
          // only once the presented word is gone or being taken this cycle
          if (!r_inflight_valid || instr_ready) begin
            mem_rd_n             = RD_ON;
            mem_addr             = r_pc;
            w_pc_nxt             = r_pc + ADDR_WIDTH'(1);
            w_inflight_valid_nxt = 1'b1;
            w_inflight_pc_nxt    = r_pc;
          end
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  assign instr    = mem_rdata;
  assign instr_pc = r_inflight_pc;
  assign busy     = (r_state == RUN);

`ifdef IFETCH_PERF_CNT_EN
  logic w_xfer;
  logic w_stall;

  assign w_xfer  = instr_valid && instr_ready;
  assign w_stall = busy && instr_valid && !instr_ready;

  ifetch_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .i_instr_inc (w_xfer),
    .i_stall_inc (w_stall),
    .o_instr_cnt (perf_instr_cnt),
    .o_stall_cnt (perf_stall_cnt)
  );
`else
  // Counters absent: no extra state in this build.
`endif

endmodule

// File: tb/tb_ifetch_ctrl.sv
// Scoreboard bench for ifetch_ctrl with a behavioural 1-cycle BRAM.
// Define IFETCH_PERF_CNT_EN to also check the perf counters.
module tb_ifetch_ctrl;

  localparam int AW = 10;
  localparam int DW = 32;

  typedef struct {
    logic [AW-1:0] pc;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst, start, halt_req, ld_valid, instr_ready, redirect_valid;
  logic [AW-1:0] ld_addr, redirect_pc;
  logic [DW-1:0] ld_data;
  logic          ld_ready, mem_rd_n, mem_wr_n, instr_valid, busy;
  logic [AW-1:0] mem_addr, instr_pc;
  logic [DW-1:0] mem_wdata, instr;
  logic [DW-1:0] mem_rdata = '0;
`ifdef IFETCH_PERF_CNT_EN
  logic [31:0]   perf_instr_cnt, perf_stall_cnt;
`endif

  logic [DW-1:0] bram [1 << AW];
  exp_t          exp_q[$];
  int            checks = 0;
  int            errors = 0;

  always #5 clk = ~clk;

  ifetch_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .halt_req       (halt_req),
    .ld_valid       (ld_valid),
    .ld_addr        (ld_addr),
    .ld_data        (ld_data),
    .ld_ready       (ld_ready),
    .mem_addr       (mem_addr),
    .mem_rd_n       (mem_rd_n),
    .mem_wr_n       (mem_wr_n),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
`ifdef IFETCH_PERF_CNT_EN
    ,
    .perf_instr_cnt (perf_instr_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  initial begin
    for (int i = 0; i < (1 << AW); i++) bram[i] = 32'hA5A5_0000 | i;
  end

  always @(posedge clk) begin
    if (!mem_wr_n) bram[mem_addr] <= mem_wdata;
    if (!mem_rd_n) mem_rdata <= bram[mem_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [AW-1:0] pc, input logic [DW-1:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Monitor: every handshake must match the oldest expected transfer.
  always @(negedge clk) begin
    if (instr_valid && instr_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_xfer: got pc %0h instr %0h, no transfer expected", instr_pc, instr);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("xfer_pc", 64'(instr_pc), 64'(e.pc));
        check("xfer_instr", 64'(instr), 64'(e.data));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] ld_words [4];

  initial begin
    ld_words[0] = 32'h11; ld_words[1] = 32'h22;
    ld_words[2] = 32'h33; ld_words[3] = 32'h44;
    rst = 1'b1; start = 1'b0; halt_req = 1'b0; ld_valid = 1'b0; instr_ready = 1'b0;
    redirect_valid = 1'b0; ld_addr = '0; redirect_pc = '0; ld_data = '0;
    step(); step();
    rst = 1'b0;
    smp();
    check("rst_valid", 64'(instr_valid), 64'd0);
    check("rst_rd_n", 64'(mem_rd_n), 64'd1);
    check("rst_wr_n", 64'(mem_wr_n), 64'd1);
    check("rst_ld_ready", 64'(ld_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_instr_pc", 64'(instr_pc), 64'd0);
`ifdef IFETCH_PERF_CNT_EN
    check("rst_perf_instr", 64'(perf_instr_cnt), 64'd0);
    check("rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif

    // Boot load of words 0..3
    for (int i = 0; i < 4; i++) begin
      step();
      ld_valid = 1'b1; ld_addr = AW'(i); ld_data = ld_words[i];
      smp();
      check("ld_wr_n", 64'(mem_wr_n), 64'd0);
      check("ld_addr", 64'(mem_addr), 64'(i));
      check("ld_wdata", 64'(mem_wdata), 64'(ld_words[i]));
      check("ld_rd_n", 64'(mem_rd_n), 64'd1);
    end
    step();
    ld_valid = 1'b0;

    // Run A: stream 0..3, loader ignored in RUN, then halt with same-cycle redirect
    start = 1'b1; instr_ready = 1'b1;
    push(0, 32'h11); push(1, 32'h22); push(2, 32'h33); push(3, 32'h44);
    smp();
    check("a_idle_busy", 64'(busy), 64'd0);
    step(); start = 1'b0;                                   // S+1
    smp();
    check("a_run_busy", 64'(busy), 64'd1);
    check("a_first_not_valid", 64'(instr_valid), 64'd0);
    check("a_issue_rd_n", 64'(mem_rd_n), 64'd0);
    check("a_issue_addr", 64'(mem_addr), 64'd0);
    step();                                                 // S+2
    smp();
    check("a_first_valid", 64'(instr_valid), 64'd1);
    step();                                                 // S+3
    ld_valid = 1'b1; ld_addr = 10'd1; ld_data = 32'hBAD0_BAD0;
    smp();
    check("a_run_wr_n", 64'(mem_wr_n), 64'd1);
    check("a_run_ld_ready", 64'(ld_ready), 64'd0);
    step(); ld_valid = 1'b0;                                // S+4
    step();                                                 // S+5
    step();                                                 // S+6
    halt_req = 1'b1; redirect_valid = 1'b1; redirect_pc = 10'd5;
    smp();
    check("a_halt_valid", 64'(instr_valid), 64'd0);
    check("a_halt_rd_n", 64'(mem_rd_n), 64'd1);
    step(); halt_req = 1'b0; redirect_valid = 1'b0;         // S+7
    smp();
    check("a_h_busy", 64'(busy), 64'd0);
    check("a_h_ld_ready", 64'(ld_ready), 64'd1);
    check("a_h_valid", 64'(instr_valid), 64'd0);
    check("a_h_rd_n", 64'(mem_rd_n), 64'd1);
`ifdef IFETCH_PERF_CNT_EN
    check("a_perf_instr", 64'(perf_instr_cnt), 64'd4);
    check("a_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    step();
    smp();
    check("a_h_rd_n_hold", 64'(mem_rd_n), 64'd1);
    check("a_q_drained", 64'(exp_q.size()), 64'd0);

    // Run B: restart at 0, backpressure on pc1, then reset mid-stall
    step();
    start = 1'b1;
    push(0, 32'h11); push(1, 32'h22); push(2, 32'h33);
    step(); start = 1'b0;                                   // S+1
    step();                                                 // S+2
    for (int k = 0; k < 3; k++) begin                       // S+3..S+5
      step(); instr_ready = 1'b0;
      smp();
      check("b_bp_valid", 64'(instr_valid), 64'd1);
      check("b_bp_pc", 64'(instr_pc), 64'd1);
      check("b_bp_instr", 64'(instr), 64'h22);
      check("b_bp_rd_n", 64'(mem_rd_n), 64'd1);
    end
    step(); instr_ready = 1'b1;                             // S+6
    smp();
    check("b_resume_rd_n", 64'(mem_rd_n), 64'd0);
    check("b_resume_addr", 64'(mem_addr), 64'd2);
    step();                                                 // S+7
    smp();
    check("b_next_pc", 64'(instr_pc), 64'd2);
    check("b_next_instr", 64'(instr), 64'h33);
    step(); instr_ready = 1'b0;                             // S+8
    smp();
`ifdef IFETCH_PERF_CNT_EN
    check("b_perf_instr", 64'(perf_instr_cnt), 64'd7);
    check("b_perf_stall", 64'(perf_stall_cnt), 64'd3);
`endif
    step(); rst = 1'b1;                                     // S+9
    step(); rst = 1'b0;                                     // S+10
    smp();
    check("b_rst_busy", 64'(busy), 64'd0);
    check("b_rst_valid", 64'(instr_valid), 64'd0);
    check("b_rst_rd_n", 64'(mem_rd_n), 64'd1);
    check("b_rst_wr_n", 64'(mem_wr_n), 64'd1);
    check("b_rst_ld_ready", 64'(ld_ready), 64'd1);
`ifdef IFETCH_PERF_CNT_EN
    check("b_rst_perf_instr", 64'(perf_instr_cnt), 64'd0);
    check("b_rst_perf_stall", 64'(perf_stall_cnt), 64'd0);
`endif
    check("b_q_drained", 64'(exp_q.size()), 64'd0);

    // Run C: redirect to 0x3FF while pc2 is presented, wrap to 0, then halt
    step();
    start = 1'b1; instr_ready = 1'b1;
    push(0, 32'h11); push(1, 32'h22);
    push(10'h3FF, 32'hA5A5_03FF); push(0, 32'h11); push(1, 32'h22);
    step(); start = 1'b0;                                   // S+1
    step();                                                 // S+2
    step();                                                 // S+3
    step();                                                 // S+4
    redirect_valid = 1'b1; redirect_pc = 10'h3FF;
    smp();
    check("c_redir_valid", 64'(instr_valid), 64'd0);
    check("c_redir_rd_n", 64'(mem_rd_n), 64'd1);
    step(); redirect_valid = 1'b0;                          // S+5
    smp();
    check("c_gap_valid", 64'(instr_valid), 64'd0);
    check("c_gap_rd_n", 64'(mem_rd_n), 64'd0);
    check("c_gap_addr", 64'(mem_addr), 64'h3FF);
    step();                                                 // S+6
    smp();
    check("c_tgt_valid", 64'(instr_valid), 64'd1);
    check("c_tgt_pc", 64'(instr_pc), 64'h3FF);
    step();                                                 // S+7
    step();                                                 // S+8
    step(); halt_req = 1'b1;                                // S+9
    smp();
    check("c_halt_valid", 64'(instr_valid), 64'd0);
    step(); halt_req = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 10'h100;
    smp();
    check("c_h_redir_rd_n", 64'(mem_rd_n), 64'd1);
    check("c_h_redir_busy", 64'(busy), 64'd0);
    step(); redirect_valid = 1'b0;
    step();
    smp();
    check("c_q_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ifetch_ctrl.md
Name: ifetch_ctrl

Overview:
- Instruction-fetch sequencer in front of the 1-cycle-latency synchronous instruction BRAM (active-low rd_n/wr_n, registered output).
- Owns the PC and loads the program through the BRAM write port at boot.
- Streams instructions to decode with a valid/ready handshake, and handles branch redirect and halt.

Parameters:
ADDR_WIDTH, 10, word-address width of instruction memory; PC width
DATA_WIDTH, 32, instruction width
RESET_PC, 0, PC value after reset and on start

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous active-high reset
start  in  1  pulse: IDLE/HALT -> RUN, PC <= RESET_PC
halt_req  in  1  pulse: stop fetching, enter HALT
ld_valid  in  1  loader write request
ld_addr  in  ADDR_WIDTH  loader word address
ld_data  in  DATA_WIDTH  loader word
ld_ready  out  1  loader may write this cycle
mem_addr  out  ADDR_WIDTH  BRAM address
mem_rd_n  out  1  BRAM read enable, active low
mem_wr_n  out  1  BRAM write enable, active low
mem_wdata  out  DATA_WIDTH  BRAM write data
mem_rdata  in  DATA_WIDTH  BRAM registered read data
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decode accepts
instr  out  DATA_WIDTH  instruction (mem_rdata passed through)
instr_pc  out  ADDR_WIDTH  address of instr
redirect_valid  in  1  branch/jump taken
redirect_pc  in  ADDR_WIDTH  new fetch target
busy  out  1  state == RUN

Behaviour:
- States (enum): IDLE, RUN, HALT. Reset -> IDLE, pc=RESET_PC, instr_valid=0, mem_rd_n=1, mem_wr_n=1, ld_ready=1, busy=0, instr_pc=0. Reset mid-fetch discards any in-flight read.
- BRAM timing: rd_n=0 with addr=A in cycle N -> mem_rdata=mem[A] in N+1. mem_rdata holds while rd_n=1, so it serves as the one-entry hold register. No other instruction storage.
- IDLE/HALT: ld_ready=1.
  - ld_valid=1 drives mem_addr=ld_addr, mem_wdata=ld_data, mem_wr_n=0 in the same cycle (combinational).
  - mem_rd_n=1.
  - start=1 -> RUN next cycle, pc=RESET_PC; a same-cycle ld_valid write still completes.
- RUN: ld_ready=0, mem_wr_n=1; ld_valid is ignored.
  - Issue the read of pc (rd_n=0, addr=pc) when !inflight_valid || instr_ready.
  - On issue: pc <= pc+1 mod 2^ADDR_WIDTH (wraps max -> 0), inflight_valid<=1, inflight_pc<=pc.
  - instr_valid = inflight_valid; instr = mem_rdata; instr_pc = inflight_pc.
  - Handshake: transfer when instr_valid && instr_ready. If no new issue, inflight_valid<=0.
  - Backpressure: instr_valid=1 && !instr_ready -> rd_n=1, outputs held stable until accepted.
  - Throughput 1 instr/cycle with instr_ready held high. First instr_valid is 2 cycles after start (RUN entry, then issue).
- Redirect (RUN only), cycle N:
  - instr_valid forced 0 in N, so no transfer is counted.
  - inflight_valid<=0 and pc<=redirect_pc; no read is issued in N.
  - Read of redirect_pc issues in N+1; instr_valid with instr_pc=redirect_pc in N+2.
  - redirect_valid outside RUN is ignored.
- halt_req (RUN):
  - Next state HALT.
  - No read issued this cycle; instr_valid forced 0; inflight_valid<=0.
  - pc is retained; start restarts from RESET_PC.
- Priority: rst > halt_req > redirect_valid > normal issue. start in RUN is ignored.

Optional Feature:
- Macro IFETCH_PERF_CNT_EN.
- Defined: adds outputs perf_instr_cnt[31:0] and perf_stall_cnt[31:0], both 0 on reset.
  - perf_instr_cnt increments per handshake.
  - perf_stall_cnt increments per RUN cycle with instr_valid && !instr_ready.
  - Both saturate at 32'hFFFF_FFFF.
- Undefined: ports and logic absent; all other behaviour identical.

Decomposition:
- Package ifetch_pkg: state enum (IDLE, RUN, HALT), RESET_PC default, rd/wr active-low level constants.
- Sub-module ifetch_perf_cnt (two saturating counters), instantiated only under IFETCH_PERF_CNT_EN.
- Issue/handshake logic stays flat in ifetch_ctrl.

Test Plan:
- Load: in IDLE, write words 0..3 = 0x11,0x22,0x33,0x44, then start with ready=1 -> instr 0x11..0x44 on consecutive cycles, instr_pc 0..3, first valid 2 cycles after start.
- Backpressure: deassert instr_ready for 3 cycles while instr_pc=1 -> mem_rd_n=1, instr=0x22 and instr_pc=1 held stable; on reassert, 0x33 follows on the next cycle with no duplicate or drop.
- Redirect: redirect_valid with redirect_pc=0x3FF while instr_pc=2 valid -> instr_valid=0 for 2 cycles, then instr_pc 0x3FF, 0x000 (wrap), 0x001.
- Halt plus same-cycle redirect: halt_req and redirect_valid together -> HALT, instr_valid=0, ld_ready=1, no reads issued; a later start resumes at RESET_PC.
- Reset mid-run: rst during backpressure -> next cycle IDLE, instr_valid=0, mem_rd_n=1, mem_wr_n=1.
- Loader ignored in RUN: ld_valid=1 during RUN -> mem_wr_n stays 1 and memory is unchanged (re-fetch verifies).
- Perf counters (IFETCH_PERF_CNT_EN): 4 accepted instructions plus 3 stall cycles -> perf_instr_cnt=4, perf_stall_cnt=3.
